// File: rtl/negedge_buf_pkg.sv
// negedge_buf_pkg: shared defaults, width helpers and reset data value for the negedge FIFO buffer
package negedge_buf_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic RST_DATA_BIT = 1'b0;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/negedge_buf_mem.sv
// negedge_buf_mem: DEPTHxWIDTH register array, negedge write (we/waddr/wdata), async clear on rst, combinational read (raddr->rdata)
module negedge_buf_mem
  import negedge_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ptr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [ptr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]          rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: {WIDTH{RST_DATA_BIT}}};
    else mem_q <= mem_d;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/negedge_fifo_buffer.sv
// negedge_fifo_buffer: FWFT FIFO updated on falling clk edge; ports in_valid/in_data/in_ready, out_valid/out_data/out_ready, count, ovf (sticky overflow under NEGEDGE_BUF_OVF_EN, else 0)
module negedge_fifo_buffer
  import negedge_buf_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         ovf
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full, empty, push, pop;
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    push = in_valid && !full;
    pop = out_ready && !empty;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d = (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  negedge_buf_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(push),
    .waddr(wr_ptr_q),
    .wdata(in_data),
    .raddr(rd_ptr_q),
    .rdata(out_data)
  );
`ifdef NEGEDGE_BUF_OVF_EN
  logic ovf_q, ovf_d;
  // a write attempt while full is dropped and remembered until reset
  always_comb ovf_d = ovf_q || (in_valid && full);
  always_ff @(negedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif
  assign in_ready = !full;
  assign out_valid = !empty;
  assign count = count_q;
endmodule

// File: tb/tb_negedge_fifo_buffer.sv
// tb_negedge_fifo_buffer: table-driven scoreboard bench for negedge_fifo_buffer
module tb_negedge_fifo_buffer;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, ovf;
  logic [W-1:0] out_data;
  logic [2:0] count;
  typedef struct {
    logic iv;
    logic [7:0] d;
    logic ordy;
    int exp_cnt;
  } vec_t;
  vec_t tbl [20];
  logic [7:0] sb [$];
  bit ovf_exp;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  negedge_fifo_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count),
    .ovf(ovf)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic chk_reset_state();
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf, 0);
  endtask
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input int exp_cnt);
    bit p, q;
    @(posedge clk);
    #1;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    chk("pre_count", count, sb.size());
    chk("pre_out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) chk("pre_head", out_data, sb[0]);
    p = iv && sb.size() < D;
    q = ordy && sb.size() > 0;
`ifdef NEGEDGE_BUF_OVF_EN
    if (iv && sb.size() == D) ovf_exp = 1'b1;
`endif
    @(negedge clk);
    #1;
    if (q) void'(sb.pop_front());
    if (p) sb.push_back(d);
    chk("count", count, exp_cnt);
    chk("model_count", count, sb.size());
    chk("in_ready", in_ready, sb.size() < D);
    chk("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) chk("head", out_data, sb[0]);
    chk("ovf", ovf, ovf_exp);
  endtask
  initial begin
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 2};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 4};
    tbl[4] = '{1'b1, 8'h55, 1'b1, 3};
    for (int i = 0; i < 10; i++) tbl[5+i] = '{1'b1, 8'(i), 1'b1, 3};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 2};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 1};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 0};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 0};
    tbl[19] = '{1'b1, 8'hA5, 1'b1, 1};
    #1 rst = 1'b1;
    #1 chk_reset_state();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].exp_cnt);
      if (i == 4) chk("full_pop_head", out_data, 8'h22);
    end
    chk("empty_push_head", out_data, 8'hA5);
    step(1'b1, 8'h66, 1'b0, 2);
    #2 rst = 1'b1;
    #1 chk_reset_state();
    sb.delete();
    ovf_exp = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      out_ready = 1'b1;
      chk("iso_count", count, 1);
      chk("iso_head", out_data, 8'h5A);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("iso_post_count", count, 1);
    chk("iso_post_head", out_data, 8'h5A);
    chk("iso_post_valid", out_valid, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
